// File: rtl/ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module : ifu_prefetch_if
// Brief  : Memory fetch, redirect and decoder-side handshake bundle of the
//          instruction prefetch unit.
// Rev    : 1.0  initial release
// ============================================================================
interface ifu_prefetch_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
);
   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic [ADDR_WIDTH-1:0]  mem_req_addr;
   logic                   mem_rsp_valid;
   logic [INSTR_WIDTH-1:0] mem_rsp_data;
   logic                   redirect_valid;
   logic [ADDR_WIDTH-1:0]  redirect_addr;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [INSTR_WIDTH-1:0] instr_data;
   logic [ADDR_WIDTH-1:0]  instr_pc;
   logic                   misalign_err;

   // Prefetch unit side
   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data,
      input  redirect_valid, redirect_addr,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready,
      output misalign_err
   );

   // Memory / decoder / branch-unit side
   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data,
      output redirect_valid, redirect_addr,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready,
      input  misalign_err
   );
endinterface
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module : ifu_prefetch
// Brief  : Sequential instruction prefetcher with a DEPTH-entry PC-tagged
//          FIFO, credit-limited fetch and flushing redirect.
//          Optional macro PF_MISALIGN_CHECK_EN: flag and align misaligned
//          redirect targets.
// Rev    : 1.0  initial release
// ============================================================================
module ifu_prefetch #(
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    INSTR_WIDTH   = 32,
   parameter int                    DEPTH         = 4,
   parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = '0,
   parameter int                    CMD_WIDTH     = 4
) (
   input  wire logic       clk,
   input  wire logic       a_reset,
   ifu_prefetch_if.master  bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W:0]        C_DEPTH = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]      C_CNT1  = CNT_W'(1);
   localparam logic [PTR_W-1:0]      C_PTR1  = PTR_W'(1);
   localparam logic [ADDR_WIDTH-1:0] C_INC   = ADDR_WIDTH'(CMD_WIDTH);

   logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       outstanding_q, outstanding_d;
   logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [INSTR_WIDTH-1:0] data_q [DEPTH];
   logic [INSTR_WIDTH-1:0] data_d [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_q   [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_d   [DEPTH];

   logic                   req_fire;
   logic                   rsp_fire;
   logic                   enq;
   logic                   deq;
   logic [ADDR_WIDTH-1:0]  redir_addr;

   // Requests are throttled so buffered plus in-flight words never exceed DEPTH
   assign bus.mem_req_valid = (({1'b0, count_q} + {1'b0, outstanding_q}) < C_DEPTH)
                              && !bus.redirect_valid && !a_reset;
   assign bus.mem_req_addr  = fetch_pc_q;
   assign bus.instr_valid   = (count_q != '0);
   assign bus.instr_data    = data_q[rd_ptr_q];
   assign bus.instr_pc      = pc_q[rd_ptr_q];

   assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
   assign rsp_fire = bus.mem_rsp_valid && (outstanding_q != '0);
   assign enq      = rsp_fire && (drop_cnt_q == '0) && !bus.redirect_valid;
   assign deq      = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;

`ifdef PF_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign redir_addr = {bus.redirect_addr[ADDR_WIDTH-1:2], 2'b00};
   assign misalign_d = misalign_q
                       | (bus.redirect_valid && (bus.redirect_addr[1:0] != 2'b00));
   assign bus.misalign_err = misalign_q;

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`else
   assign redir_addr       = bus.redirect_addr;
   assign bus.misalign_err = 1'b0;
`endif

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      data_d        = data_q;
      pc_d          = pc_q;

      case ({req_fire, rsp_fire})
         2'b10:   outstanding_d = outstanding_q + C_CNT1;
         2'b01:   outstanding_d = outstanding_q - C_CNT1;
         default: outstanding_d = outstanding_q;
      endcase

      if (bus.redirect_valid) begin
         // Everything still in flight after this edge belongs to the old stream
         fetch_pc_d = redir_addr;
         rsp_pc_d   = redir_addr;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_cnt_d = outstanding_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + C_INC;
         end
         if (rsp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - C_CNT1;
         end
         if (enq) begin
            data_d[wr_ptr_q] = bus.mem_rsp_data;
            pc_d[wr_ptr_q]   = rsp_pc_q;
            wr_ptr_d         = wr_ptr_q + C_PTR1;
            rsp_pc_d         = rsp_pc_q + C_INC;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + C_PTR1;
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + C_CNT1;
            2'b01:   count_d = count_q - C_CNT1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         fetch_pc_q    <= START_ADDRESS;
         rsp_pc_q      <= START_ADDRESS;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         data_q        <= data_d;
         pc_q          <= pc_d;
      end
   end

   a_credit: assert property (@(posedge clk) disable iff (a_reset)
      (({1'b0, count_q} + {1'b0, outstanding_q}) <= C_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module : tb_ifu_prefetch
// Brief  : Self-checking bench for ifu_prefetch: latency-programmable memory
//          model plus a PC/data scoreboard of the expected decoder stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ifu_prefetch;
   localparam int              AW    = 32;
   localparam int              IW    = 32;
   localparam int              DEPTH = 4;
   localparam int              CMD   = 4;
   localparam logic [AW-1:0]   START = 32'h0;

   logic clk = 1'b0;
   logic a_reset;
   always #5 clk = ~clk;

   ifu_prefetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

   ifu_prefetch #(
      .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH),
      .START_ADDRESS(START), .CMD_WIDTH(CMD)
   ) dut (
      .clk(clk),
      .a_reset(a_reset),
      .bus(bus)
   );

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            lat   = 1;
   int            n_req = 0;
   int            n_deq = 0;
   logic [AW-1:0] exp_fetch;
   logic [AW-1:0] first_deq_pc;
   logic [AW-1:0] exp_pc_q   [$];
   logic [AW-1:0] req_log    [$];
   logic [AW-1:0] mem_addr_q [$];
   int            mem_due_q  [$];

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   function automatic logic [AW-1:0] redir_target(input logic [AW-1:0] a);
`ifdef PF_MISALIGN_CHECK_EN
      return {a[AW-1:2], 2'b00};
`else
      return a;
`endif
   endfunction

   // One clock: drive memory response, observe handshakes, update scoreboard.
   task automatic cycle();
      logic          req_fire;
      logic          deq;
      logic [AW-1:0] e;
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = mem_word(mem_addr_q[0]);
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = '0;
      end
      #1;
      req_fire = bus.mem_req_valid && bus.mem_req_ready;
      deq      = bus.instr_valid && bus.instr_ready;
      if (bus.redirect_valid) begin
         total++;
         if (bus.mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_req_valid: got %b expected 0", bus.mem_req_valid);
         end
         exp_pc_q.delete();
         exp_fetch = redir_target(bus.redirect_addr);
      end else begin
         if (deq) begin
            n_deq++;
            if (n_deq == 1) first_deq_pc = bus.instr_pc;
            total++;
            if (exp_pc_q.size() == 0) begin
               bad++;
               $display("FAIL deq_unexpected: got pc %h expected no entry", bus.instr_pc);
            end else begin
               e = exp_pc_q.pop_front();
               if (bus.instr_pc !== e || bus.instr_data !== mem_word(e)) begin
                  bad++;
                  $display("FAIL deq_entry: got pc %h data %h expected pc %h data %h",
                           bus.instr_pc, bus.instr_data, e, mem_word(e));
               end
            end
         end
         if (req_fire) begin
            n_req++;
            req_log.push_back(bus.mem_req_addr);
            total++;
            if (bus.mem_req_addr !== exp_fetch) begin
               bad++;
               $display("FAIL req_addr: got %h expected %h", bus.mem_req_addr, exp_fetch);
            end
            exp_pc_q.push_back(exp_fetch);
            mem_addr_q.push_back(bus.mem_req_addr);
            mem_due_q.push_back(cyc + lat);
            exp_fetch = exp_fetch + AW'(CMD);
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      a_reset            = 1'b1;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_data   = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_pc_q.delete();
      req_log.delete();
      exp_fetch = START;
      n_req     = 0;
      n_deq     = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      a_reset = 1'b0;
   endtask

   task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic test_reset();
      bus.mem_req_ready = 1'b0;
      bus.instr_ready   = 1'b0;
      a_reset           = 1'b1;
      @(posedge clk);
      #1;
      check("rst_instr_valid", AW'(bus.instr_valid), '0);
      check("rst_req_valid", AW'(bus.mem_req_valid), '0);
      check("rst_instr_data", bus.instr_data, '0);
      check("rst_instr_pc", bus.instr_pc, '0);
      check("rst_misalign", AW'(bus.misalign_err), '0);
      do_reset();
      #1;
      check("rel_req_valid", AW'(bus.mem_req_valid), 1);
      check("rel_req_addr", bus.mem_req_addr, START);
   endtask

   task automatic test_stream();
      int d0;
      do_reset();
      lat = 1;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b1;
      repeat (12) cycle();
      d0 = n_deq;
      repeat (10) cycle();
      check("stream_first_pc", first_deq_pc, START);
      check("stream_rate", AW'(n_deq - d0), 10);
   endtask

   task automatic test_stall();
      do_reset();
      lat = 1;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b0;
      repeat (10) cycle();
      check("stall_req_count", AW'(n_req), 4);
      check("stall_req_valid", AW'(bus.mem_req_valid), 0);
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 20 && n_deq < 4; i++) cycle();
      check("stall_drain_count", AW'(n_deq), 4);
      check("stall_first_pc", first_deq_pc, START);
      if (req_log.size() > 4) check("stall_resume_addr", req_log[4], START + 32'h10);
      else check("stall_resume_count", AW'(req_log.size()), 5);
   endtask

   task automatic test_redirect_drop();
      do_reset();
      lat = 3;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b1;
      cycle();
      cycle();
      bus.mem_req_ready  = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h100;
      cycle();
      bus.redirect_valid = 1'b0;
      bus.mem_req_ready  = 1'b1;
      n_deq = 0;
      for (int i = 0; i < 30 && n_deq < 3; i++) cycle();
      check("drop_deq_count", AW'(n_deq), 3);
      check("drop_first_pc", first_deq_pc, 32'h100);
   endtask

   task automatic test_redirect_collision();
      do_reset();
      lat = 2;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b1;
      repeat (8) cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h40;
      cycle();
      bus.redirect_valid = 1'b0;
      #1;
      check("coll_next_addr", bus.mem_req_addr, 32'h40);
      check("coll_next_valid", AW'(bus.mem_req_valid), 1);
      n_deq = 0;
      for (int i = 0; i < 20 && n_deq < 4; i++) cycle();
      check("coll_deq_count", AW'(n_deq), 4);
      check("coll_first_pc", first_deq_pc, 32'h40);
   endtask

   task automatic test_back_to_back();
      do_reset();
      lat = 2;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b1;
      repeat (3) cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h200;
      cycle();
      bus.redirect_addr  = 32'h300;
      cycle();
      bus.redirect_valid = 1'b0;
      n_deq = 0;
      for (int i = 0; i < 20 && n_deq < 3; i++) cycle();
      check("b2b_deq_count", AW'(n_deq), 3);
      check("b2b_first_pc", first_deq_pc, 32'h300);
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat = 1;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b0;
      repeat (3) cycle();
      bus.mem_req_ready = 1'b0;
      repeat (3) cycle();
      check("mid_fifo_valid", AW'(bus.instr_valid), 1);
      #2;
      a_reset = 1'b1;
      #1;
      check("mid_instr_valid", AW'(bus.instr_valid), 0);
      check("mid_req_valid", AW'(bus.mem_req_valid), 0);
      bus.mem_req_ready = 1'b1;
      do_reset();
      #1;
      check("mid_restart_addr", bus.mem_req_addr, START);
      check("mid_restart_valid", AW'(bus.mem_req_valid), 1);
      check("mid_restart_empty", AW'(bus.instr_valid), 0);
   endtask

   task automatic test_misalign();
      do_reset();
      lat = 1;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b1;
      repeat (2) cycle();
      check("mis_before", AW'(bus.misalign_err), 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h102;
      cycle();
      bus.redirect_valid = 1'b0;
      #1;
`ifdef PF_MISALIGN_CHECK_EN
      check("mis_flag", AW'(bus.misalign_err), 1);
      check("mis_addr", bus.mem_req_addr, 32'h100);
      repeat (5) cycle();
      check("mis_sticky", AW'(bus.misalign_err), 1);
`else
      check("mis_flag_off", AW'(bus.misalign_err), 0);
      check("mis_addr_raw", bus.mem_req_addr, 32'h102);
      repeat (5) cycle();
      check("mis_still_off", AW'(bus.misalign_err), 0);
`endif
   endtask

   initial begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_data   = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;
      bus.instr_ready    = 1'b0;
      exp_fetch          = START;
      first_deq_pc       = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_collision();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
